// File: rtl/mem_blk_pkg.sv
// rtl/mem_blk_pkg.sv - shared types and constants for the memory block responder
package mem_blk_pkg;

    localparam int BLK_BITS  = 32;
    localparam int WORD_BITS = 16;
    localparam int BEATS     = 2;

    typedef enum logic {
        MEM_REFILL,
        MEM_WRITEBACK
    } blk_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_WR0,
        S_WR1,
        S_RD0,
        S_RD1,
        S_RD2,
        S_RESP
    } blk_state_t;

    function automatic blk_state_t first_beat(input blk_op_t op);
        return (op == MEM_WRITEBACK) ? S_WR0 : S_RD0;
    endfunction

endpackage

// File: rtl/mem_word_ram.sv
// rtl/mem_word_ram.sv - single-port synchronous word RAM, 1-cycle read
module mem_word_ram
    import mem_blk_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [WORD_BITS-1:0] wdata,
    output logic [WORD_BITS-1:0] rdata
);

    logic [WORD_BITS-1:0] mem [2**ADDR_W];

    // No reset: contents must survive a responder reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_block_responder.sv
// rtl/mem_block_responder.sv - block refill/writeback responder with programmable latency
// Optional: MEM_ALIGN_CHECK_EN rejects non-4-byte-aligned requests with rsp_err.
module mem_block_responder
    import mem_blk_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [15:0]         req_addr,
    input  logic [BLK_BITS-1:0] req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [BLK_BITS-1:0] rsp_rdata,
    output logic                rsp_err
);

    blk_state_t           state;
    blk_op_t              op;
    logic [ADDR_W-1:0]    lo_idx;
    logic [BLK_BITS-1:0]  wdata_q;
    logic [3:0]           wait_cnt;

    logic                 ram_en;
    logic                 ram_we;
    logic [ADDR_W-1:0]    ram_addr;
    logic [WORD_BITS-1:0] ram_wdata;
    logic [WORD_BITS-1:0] ram_rdata;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[15:ADDR_W+1], req_addr[1:0]};

    assign req_ready = (state == S_IDLE);

    // RAM controls decode straight from state so a reset drops write-enable at once.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = lo_idx;
        ram_wdata = wdata_q[WORD_BITS-1:0];
        case (state)
            S_WR0: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
            end
            S_WR1: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = {lo_idx[ADDR_W-1:1], 1'b1};
                ram_wdata = wdata_q[BLK_BITS-1:WORD_BITS];
            end
            S_RD0: ram_en = 1'b1;
            S_RD1: begin
                ram_en   = 1'b1;
                ram_addr = {lo_idx[ADDR_W-1:1], 1'b1};
            end
            default: ;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            op        <= MEM_REFILL;
            lo_idx    <= '0;
            wdata_q   <= '0;
            wait_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    op        <= req_write ? MEM_WRITEBACK : MEM_REFILL;
                    lo_idx    <= {req_addr[ADDR_W:2], 1'b0};
                    wdata_q   <= req_wdata;
                    wait_cnt  <= '0;
                    rsp_rdata <= '0;
`ifdef MEM_ALIGN_CHECK_EN
                    err_q     <= (req_addr[1:0] != 2'b00);
                    if (req_addr[1:0] != 2'b00) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                    end else
`endif
                    if (LATENCY == 0)
                        state <= first_beat(req_write ? MEM_WRITEBACK : MEM_REFILL);
                    else
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == 4'(LATENCY - 1)) begin
                        wait_cnt <= '0;
                        state    <= first_beat(op);
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_WR0: state <= S_WR1;
                S_WR1: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                end
                S_RD0: state <= S_RD1;
                S_RD1: begin
                    rsp_rdata[WORD_BITS-1:0] <= ram_rdata;
                    state                    <= S_RD2;
                end
                S_RD2: begin
                    rsp_rdata[BLK_BITS-1:WORD_BITS] <= ram_rdata;
                    state                           <= S_RESP;
                    rsp_valid                       <= 1'b1;
                end
                S_RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    mem_word_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule
